debounce_bank: RTL and testbench

Parametrised multi-channel switch debouncer with edge detection. Each of `NUM_CH` asynchronous switch inputs is synchronised, then filtered by its own counter. A channel's debounced state changes only after the input has held a new level for `DEBOUNCE_LIMIT` consecutive clocks. The block also emits one-cycle rise and fall pulses per channel. It sits between the board switch pins and all downstream control logic (counters, FSMs, LED drivers) and replaces single-channel debouncers.

---
 rtl/debounce_bank.sv | 82 ++++++++
 tb/tb_debounce_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch debouncer with registered rise/fall pulses.
// Each channel is synchronised by two flops, then accepts a new level only after
// it has held for DEBOUNCE_LIMIT consecutive clocks.
module debounce_bank #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter logic        INIT_STATE     = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic              o_Any_Change
);

  localparam int unsigned       CW       = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [NUM_CH-1:0] INIT_VEC = {NUM_CH{INIT_STATE}};

  logic [NUM_CH-1:0] sync0;
  logic [NUM_CH-1:0] sync;
  logic [CW-1:0]     count      [NUM_CH];
  logic [CW-1:0]     count_next [NUM_CH];
  logic [NUM_CH-1:0] state_next;
  logic [NUM_CH-1:0] rise_next;
  logic [NUM_CH-1:0] fall_next;

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync0 <= INIT_VEC;
      sync  <= INIT_VEC;
    end else begin
      sync0 <= i_Switch;
      sync  <= sync0;
    end
  end

  // Per-channel filter: restart on agreement, accept at the last count, else count up.
  always_comb begin
    state_next = o_Switch;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_next[i] = count[i];
      if (sync[i] == o_Switch[i]) begin
        count_next[i] = '0;
      end else if (count[i] == CNT_LAST) begin
        count_next[i] = '0;
        state_next[i] = sync[i];
        rise_next[i]  = sync[i];
        fall_next[i]  = ~sync[i];
      end else begin
        count_next[i] = count[i] + CW'(1);
      end
    end
  end

  // Counters, debounced state and pulse outputs; reset never produces a pulse.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i] <= '0;
      end
      o_Switch     <= INIT_VEC;
      o_Rise       <= '0;
      o_Fall       <= '0;
      o_Any_Change <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i] <= count_next[i];
      end
      o_Switch     <= state_next;
      o_Rise       <= rise_next;
      o_Fall       <= fall_next;
      o_Any_Change <= |(rise_next | fall_next);
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed checks of debounce_bank with limits 4 and 1,
// followed by a random bounce run against a cycle model.
module tb_debounce_bank;

  localparam int unsigned L4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw4 = 4'b0000;
  logic [3:0] out4, rise4, fall4;
  logic       any4;
  logic [3:0] sw1 = 4'b0000;
  logic [3:0] out1, rise1, fall1;
  logic       any1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(L4), .INIT_STATE(1'b0)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Switch(sw4),
    .o_Switch(out4), .o_Rise(rise4), .o_Fall(fall4), .o_Any_Change(any4)
  );

  debounce_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(1), .INIT_STATE(1'b0)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Switch(sw1),
    .o_Switch(out1), .o_Rise(rise1), .o_Fall(fall1), .o_Any_Change(any1)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] m_s0, m_s1, m_st, m_r, m_f, applied;
  int         m_cnt [4];

  initial begin
    // Reset state
    step(2);
    check("rst_out4", out4, 4'b0000);
    check("rst_rise4", rise4, 4'b0000);
    check("rst_fall4", fall4, 4'b0000);
    check("rst_any4", 4'(any4), 4'b0000);
    check("rst_out1", out1, 4'b0000);
    rst = 1'b0;
    step(1);

    // 1: single rise on ch0, six edges after the input change
    sw4 = 4'b0001;
    step(5);
    check("t1_out_early", out4, 4'b0000);
    check("t1_rise_early", rise4, 4'b0000);
    step(1);
    check("t1_out", out4, 4'b0001);
    check("t1_rise", rise4, 4'b0001);
    check("t1_any", 4'(any4), 4'b0001);
    step(1);
    check("t1_rise_off", rise4, 4'b0000);
    check("t1_any_off", 4'(any4), 4'b0000);
    check("t1_out_hold", out4, 4'b0001);

    // 2: bounce on ch1 never reaches four stable samples
    sw4[1] = 1'b1; step(3);
    sw4[1] = 1'b0; step(1);
    sw4[1] = 1'b1; step(3);
    sw4[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t2_bounce_out", out4, 4'b0001);
      check("t2_bounce_rise", rise4, 4'b0000);
      check("t2_bounce_any", 4'(any4), 4'b0000);
    end
    sw4[1] = 1'b1;
    step(5);
    check("t2_out_early", out4, 4'b0001);
    step(1);
    check("t2_out", out4, 4'b0011);
    check("t2_rise", rise4, 4'b0010);
    step(1);
    check("t2_rise_off", rise4, 4'b0000);

    // 3: ch2 and ch3 change together
    sw4 = 4'b1111;
    step(5);
    check("t3_rise_early", rise4, 4'b0000);
    step(1);
    check("t3_rise", rise4, 4'b1100);
    check("t3_out_r", out4, 4'b1111);
    check("t3_any_r", 4'(any4), 4'b0001);
    step(1);
    check("t3_any_r_off", 4'(any4), 4'b0000);
    sw4 = 4'b0011;
    step(5);
    check("t3_fall_early", fall4, 4'b0000);
    step(1);
    check("t3_fall", fall4, 4'b1100);
    check("t3_out_f", out4, 4'b0011);
    check("t3_any_f", 4'(any4), 4'b0001);
    step(1);
    check("t3_any_f_off", 4'(any4), 4'b0000);
    check("t3_fall_off", fall4, 4'b0000);

    // 4: reset while ch0 is mid-count
    sw4 = 4'b0010;
    step(6);
    check("t4_pre_fall", fall4, 4'b0001);
    check("t4_pre_out", out4, 4'b0010);
    sw4 = 4'b0001;
    step(4);
    check("t4_midcount_out", out4, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    check("t4_async_out", out4, 4'b0000);
    check("t4_async_rise", rise4, 4'b0000);
    check("t4_async_fall", fall4, 4'b0000);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t4_post_rise", rise4, 4'b0000);
      check("t4_post_fall", fall4, 4'b0000);
      check("t4_post_out", out4, 4'b0000);
    end
    step(1);
    check("t4_out", out4, 4'b0001);
    check("t4_rise", rise4, 4'b0001);
    step(1);
    check("t4_rise_off", rise4, 4'b0000);

    // 5: limit 1, toggle ch0 every three clocks
    for (int t = 0; t < 6; t++) begin
      logic [3:0] old_v, new_v;
      old_v = {3'b000, sw1[0]};
      sw1[0] = ~sw1[0];
      new_v = {3'b000, sw1[0]};
      step(2);
      check("t5_out_old", out1, old_v);
      check("t5_pulse_idle", rise1 | fall1, 4'b0000);
      step(1);
      check("t5_out_new", out1, new_v);
      check("t5_rise", rise1, new_v);
      check("t5_fall", fall1, old_v);
      check("t5_any", 4'(any1), 4'b0001);
    end

    // 6: random bounce against a cycle model
    sw4 = 4'b0000;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    m_s0 = '0; m_s1 = '0; m_st = '0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(5) == 0) sw4[c] = ~sw4[c];
      end
      applied = sw4;
      step(1);
      m_r = '0;
      m_f = '0;
      for (int c = 0; c < 4; c++) begin
        if (m_s1[c] == m_st[c]) begin
          m_cnt[c] = 0;
        end else if (m_cnt[c] == int'(L4) - 1) begin
          m_st[c]  = m_s1[c];
          m_r[c]   = m_s1[c];
          m_f[c]   = ~m_s1[c];
          m_cnt[c] = 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
      m_s1 = m_s0;
      m_s0 = applied;
      check("t6_out", out4, m_st);
      check("t6_rise", rise4, m_r);
      check("t6_fall", fall4, m_f);
      check("t6_any", 4'(any4), 4'(|(m_r | m_f)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
